// File: rtl/mem_access_unit_pkg.sv
// Shared definitions for the MEM-stage memory access unit and the decode stage:
// FSM states, funct3 access encodings and load/store opcodes.
package mem_access_unit_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        DONE = 2'd2
    } state_e;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    localparam logic [6:0] OPC_LOAD  = 7'b0000011;
    localparam logic [6:0] OPC_STORE = 7'b0100011;

endpackage

// File: rtl/mem_access_unit_load_extender.sv
// Selects the addressed byte/half-word lane of a bus read word and
// sign- or zero-extends it according to funct3.
module mem_access_unit_load_extender
    import mem_access_unit_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic [DATA_W-1:0] word,
    input  logic [1:0]        ofs,
    input  logic [2:0]        funct3,
    output logic [DATA_W-1:0] data
);

    logic signed [7:0]  byte_s;
    logic signed [15:0] half_s;

    always_comb begin
        byte_s = $signed(word[{ofs, 3'b000} +: 8]);
        half_s = $signed(ofs[1] ? word[31:16] : word[15:0]);
        case (funct3)
            F3_B:    data = DATA_W'(byte_s);
            F3_BU:   data = DATA_W'($unsigned(byte_s));
            F3_H:    data = DATA_W'(half_s);
            F3_HU:   data = DATA_W'($unsigned(half_s));
            default: data = word;
        endcase
    end

endmodule

// File: rtl/mem_access_unit.sv
// MEM-stage memory access unit: turns one pipeline load/store into a req/ack
// bus transaction, stalls the pipeline meanwhile and returns extended load data.
module mem_access_unit
    import mem_access_unit_pkg::*;
#(
    parameter int ADDR_W      = 32,
    parameter int DATA_W      = 32,
    parameter int TIMEOUT_CYC = 64
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              mreq,
    input  logic              mem_write,
    input  logic [2:0]        funct3,
    input  logic              flush,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output logic              stall,
    output logic [DATA_W-1:0] rdata,
    output logic              rdata_valid,
    output logic              access_err,
    output logic              timeout_err,
    output logic              bus_req,
    output logic              bus_we,
    output logic [ADDR_W-1:0] bus_addr,
    output logic [3:0]        bus_be,
    output logic [DATA_W-1:0] bus_wdata,
    input  logic              bus_ack,
    input  logic [DATA_W-1:0] bus_rdata
);

    localparam int CNT_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT_CYC - 1);

    function automatic logic [3:0] be_for(input logic [2:0] f3, input logic [1:0] ofs);
        case (f3)
            F3_B, F3_BU: be_for = 4'b0001 << ofs;
            F3_H, F3_HU: be_for = 4'b0011 << ofs;
            default:     be_for = 4'b1111;
        endcase
    endfunction

    function automatic logic [DATA_W-1:0] replicate(input logic [2:0] f3, input logic [DATA_W-1:0] wd);
        case (f3)
            F3_B:    replicate = {4{wd[7:0]}};
            F3_H:    replicate = {2{wd[15:0]}};
            default: replicate = wd;
        endcase
    endfunction

    function automatic logic illegal(input logic [2:0] f3, input logic [1:0] ofs, input logic we);
        case (f3)
            F3_B, F3_BU: illegal = 1'b0;
            F3_H, F3_HU: illegal = ofs[0];
            F3_W:        illegal = (ofs != 2'b00);
            default:     illegal = 1'b1;
        endcase
        illegal = illegal | (we & f3[2]);
    endfunction

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              bus_req_q, bus_req_d;
    logic              bus_we_q, bus_we_d;
    logic [ADDR_W-1:0] bus_addr_q, bus_addr_d;
    logic [3:0]        bus_be_q, bus_be_d;
    logic [DATA_W-1:0] bus_wdata_q, bus_wdata_d;
    logic [2:0]        f3_q, f3_d;
    logic [1:0]        ofs_q, ofs_d;
    logic              flushed_q, flushed_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic              rdata_valid_q, rdata_valid_d;
    logic              timeout_err_q, timeout_err_d;
    logic [DATA_W-1:0] ext_data;
    logic              req_ok;

    mem_access_unit_load_extender #(.DATA_W(DATA_W)) u_ext (
        .word   (bus_rdata),
        .ofs    (ofs_q),
        .funct3 (f3_q),
        .data   (ext_data)
    );

    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        bus_req_d     = bus_req_q;
        bus_we_d      = bus_we_q;
        bus_addr_d    = bus_addr_q;
        bus_be_d      = bus_be_q;
        bus_wdata_d   = bus_wdata_q;
        f3_d          = f3_q;
        ofs_d         = ofs_q;
        flushed_d     = flushed_q;
        rdata_d       = rdata_q;
        rdata_valid_d = 1'b0;
        timeout_err_d = 1'b0;
        stall         = 1'b0;
        access_err    = 1'b0;
        req_ok        = mreq & ~flush;

        case (state_q)
            IDLE: begin
                access_err = req_ok & illegal(funct3, addr[1:0], mem_write);
                if (req_ok && !access_err) begin
                    stall       = 1'b1;
                    bus_req_d   = 1'b1;
                    bus_we_d    = mem_write;
                    bus_addr_d  = {addr[ADDR_W-1:2], 2'b00};
                    bus_be_d    = be_for(funct3, addr[1:0]);
                    bus_wdata_d = replicate(funct3, wdata);
                    f3_d        = funct3;
                    ofs_d       = addr[1:0];
                    flushed_d   = 1'b0;
                    cnt_d       = '0;
                    state_d     = REQ;
                end
            end
            REQ: begin
                stall     = 1'b1;
                flushed_d = flushed_q | flush;
                if (bus_ack) begin
                    bus_req_d = 1'b0;
                    cnt_d     = '0;
                    state_d   = DONE;
                    if (!bus_we_q) begin
                        rdata_d       = ext_data;
                        rdata_valid_d = ~(flushed_q | flush);
                    end
                end else if (cnt_q == CNT_MAX) begin
                    // Abort: the bus never answered, hand back zero without a valid pulse.
                    bus_req_d     = 1'b0;
                    cnt_d         = '0;
                    timeout_err_d = 1'b1;
                    rdata_d       = '0;
                    state_d       = DONE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= IDLE;
            cnt_q         <= '0;
            bus_req_q     <= 1'b0;
            bus_we_q      <= 1'b0;
            bus_addr_q    <= '0;
            bus_be_q      <= '0;
            bus_wdata_q   <= '0;
            f3_q          <= '0;
            ofs_q         <= '0;
            flushed_q     <= 1'b0;
            rdata_q       <= '0;
            rdata_valid_q <= 1'b0;
            timeout_err_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            bus_req_q     <= bus_req_d;
            bus_we_q      <= bus_we_d;
            bus_addr_q    <= bus_addr_d;
            bus_be_q      <= bus_be_d;
            bus_wdata_q   <= bus_wdata_d;
            f3_q          <= f3_d;
            ofs_q         <= ofs_d;
            flushed_q     <= flushed_d;
            rdata_q       <= rdata_d;
            rdata_valid_q <= rdata_valid_d;
            timeout_err_q <= timeout_err_d;
        end
    end

    assign bus_req     = bus_req_q;
    assign bus_we      = bus_we_q;
    assign bus_addr    = bus_addr_q;
    assign bus_be      = bus_be_q;
    assign bus_wdata   = bus_wdata_q;
    assign rdata       = rdata_q;
    assign rdata_valid = rdata_valid_q;
    assign timeout_err = timeout_err_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed self-checking bench for mem_access_unit: loads, stores, access
// errors, bus timeout, flush and asynchronous reset during a transaction.
`timescale 1ns/1ps
module tb_mem_access_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        mreq;
    logic        mem_write;
    logic [2:0]  funct3;
    logic        flush;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        stall;
    logic [31:0] rdata;
    logic        rdata_valid;
    logic        access_err;
    logic        timeout_err;
    logic        bus_req;
    logic        bus_we;
    logic [31:0] bus_addr;
    logic [3:0]  bus_be;
    logic [31:0] bus_wdata;
    logic        bus_ack;
    logic [31:0] bus_rdata;

    int n_cmp = 0;
    int n_err = 0;

    mem_access_unit dut (
        .clk         (clk),
        .rst         (rst),
        .mreq        (mreq),
        .mem_write   (mem_write),
        .funct3      (funct3),
        .flush       (flush),
        .addr        (addr),
        .wdata       (wdata),
        .stall       (stall),
        .rdata       (rdata),
        .rdata_valid (rdata_valid),
        .access_err  (access_err),
        .timeout_err (timeout_err),
        .bus_req     (bus_req),
        .bus_we      (bus_we),
        .bus_addr    (bus_addr),
        .bus_be      (bus_be),
        .bus_wdata   (bus_wdata),
        .bus_ack     (bus_ack),
        .bus_rdata   (bus_rdata)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic issue(input logic we, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] wd);
        mreq = 1'b1; mem_write = we; funct3 = f3; addr = a; wdata = wd;
    endtask

    initial begin
        rst = 1'b1; mreq = 1'b0; mem_write = 1'b0; funct3 = 3'b000; flush = 1'b0;
        addr = '0; wdata = '0; bus_ack = 1'b0; bus_rdata = '0;
        tick(); tick();
        chk("rst_bus_req", 32'(bus_req), 32'd0);
        chk("rst_rdata", rdata, 32'h0);
        chk("rst_rdata_valid", 32'(rdata_valid), 32'd0);
        chk("rst_timeout_err", 32'(timeout_err), 32'd0);
        chk("rst_bus_be", 32'(bus_be), 32'h0);
        chk("rst_stall", 32'(stall), 32'd0);
        rst = 1'b0;
        tick();

        // lw 0x104, ack in second REQ cycle
        issue(1'b0, 3'b010, 32'h0000_0104, 32'h0);
        #1;
        chk("lw_stall_idle", 32'(stall), 32'd1);
        chk("lw_access_err", 32'(access_err), 32'd0);
        tick();
        chk("lw_bus_req", 32'(bus_req), 32'd1);
        chk("lw_bus_addr", bus_addr, 32'h0000_0104);
        chk("lw_bus_be", 32'(bus_be), 32'hF);
        chk("lw_bus_we", 32'(bus_we), 32'd0);
        chk("lw_stall_req1", 32'(stall), 32'd1);
        tick();
        bus_ack = 1'b1; bus_rdata = 32'hDEAD_BEEF;
        #1;
        chk("lw_stall_req2", 32'(stall), 32'd1);
        tick();
        bus_ack = 1'b0; mreq = 1'b0;
        chk("lw_done_bus_req", 32'(bus_req), 32'd0);
        chk("lw_rdata", rdata, 32'hDEAD_BEEF);
        chk("lw_rdata_valid", 32'(rdata_valid), 32'd1);
        chk("lw_done_stall", 32'(stall), 32'd0);
        tick();
        chk("lw_valid_pulse_end", 32'(rdata_valid), 32'd0);

        // lb 0x103 then back-to-back lbu of the same word
        issue(1'b0, 3'b000, 32'h0000_0103, 32'h0);
        tick();
        chk("lb_bus_be", 32'(bus_be), 32'h8);
        chk("lb_bus_addr", bus_addr, 32'h0000_0100);
        bus_ack = 1'b1; bus_rdata = 32'h80FF_0000;
        tick();
        bus_ack = 1'b0; mreq = 1'b0;
        chk("lb_rdata", rdata, 32'hFFFF_FF80);
        chk("lb_rdata_valid", 32'(rdata_valid), 32'd1);
        tick();
        issue(1'b0, 3'b100, 32'h0000_0103, 32'h0);
        #1;
        chk("lbu_accept_first_idle", 32'(stall), 32'd1);
        tick();
        bus_ack = 1'b1;
        tick();
        bus_ack = 1'b0; mreq = 1'b0;
        chk("lbu_rdata", rdata, 32'h0000_0080);
        tick();

        // lh 0x102: upper half 0x8001 sign-extended
        issue(1'b0, 3'b001, 32'h0000_0102, 32'h0);
        tick();
        chk("lh_bus_be", 32'(bus_be), 32'hC);
        bus_ack = 1'b1; bus_rdata = 32'h8001_7FFF;
        tick();
        bus_ack = 1'b0; mreq = 1'b0;
        chk("lh_rdata", rdata, 32'hFFFF_8001);
        tick();

        // sh 0x22
        issue(1'b1, 3'b001, 32'h0000_0022, 32'h1234_ABCD);
        tick();
        chk("sh_bus_we", 32'(bus_we), 32'd1);
        chk("sh_bus_be", 32'(bus_be), 32'hC);
        chk("sh_bus_wdata", bus_wdata, 32'hABCD_ABCD);
        chk("sh_bus_addr", bus_addr, 32'h0000_0020);
        bus_ack = 1'b1; bus_rdata = 32'h5555_5555;
        tick();
        bus_ack = 1'b0; mreq = 1'b0; mem_write = 1'b0;
        chk("sh_no_rdata_valid", 32'(rdata_valid), 32'd0);
        chk("sh_rdata_kept", rdata, 32'hFFFF_8001);
        chk("sh_done_stall", 32'(stall), 32'd0);
        tick();

        // misaligned / illegal accesses
        issue(1'b0, 3'b010, 32'h0000_0006, 32'h0);
        #1;
        chk("lw_mis_err", 32'(access_err), 32'd1);
        chk("lw_mis_stall", 32'(stall), 32'd0);
        tick();
        chk("lw_mis_no_req", 32'(bus_req), 32'd0);
        chk("lw_mis_err_hold", 32'(access_err), 32'd1);
        flush = 1'b1;
        #1;
        chk("lw_mis_flush_no_err", 32'(access_err), 32'd0);
        flush = 1'b0;
        issue(1'b1, 3'b100, 32'h0000_0000, 32'h0);
        #1;
        chk("store_unsigned_err", 32'(access_err), 32'd1);
        issue(1'b0, 3'b011, 32'h0000_0000, 32'h0);
        #1;
        chk("f3_011_err", 32'(access_err), 32'd1);
        chk("f3_011_stall", 32'(stall), 32'd0);
        tick();
        chk("illegal_no_req", 32'(bus_req), 32'd0);
        mreq = 1'b0;

        // bus_ack while idle is ignored
        bus_ack = 1'b1; bus_rdata = 32'h1111_1111;
        tick();
        bus_ack = 1'b0;
        chk("idle_ack_no_req", 32'(bus_req), 32'd0);
        chk("idle_ack_no_valid", 32'(rdata_valid), 32'd0);
        chk("idle_ack_rdata_kept", rdata, 32'hFFFF_8001);

        // timeout: 64 REQ cycles without ack
        issue(1'b0, 3'b010, 32'h0000_0200, 32'h0);
        tick();
        for (int i = 0; i < 63; i++) tick();
        chk("to_req_cycle64", 32'(bus_req), 32'd1);
        chk("to_no_err_yet", 32'(timeout_err), 32'd0);
        tick();
        mreq = 1'b0;
        chk("to_bus_req_drop", 32'(bus_req), 32'd0);
        chk("to_err_pulse", 32'(timeout_err), 32'd1);
        chk("to_rdata_zero", rdata, 32'h0);
        chk("to_stall_release", 32'(stall), 32'd0);
        tick();
        chk("to_err_one_cycle", 32'(timeout_err), 32'd0);

        // flush during REQ: transaction completes, no valid pulse
        issue(1'b0, 3'b010, 32'h0000_0104, 32'h0);
        tick();
        flush = 1'b1;
        #1;
        chk("fl_stall", 32'(stall), 32'd1);
        chk("fl_bus_req", 32'(bus_req), 32'd1);
        tick();
        flush = 1'b0; bus_ack = 1'b1; bus_rdata = 32'h0BAD_F00D;
        tick();
        bus_ack = 1'b0; mreq = 1'b0;
        chk("fl_rdata", rdata, 32'h0BAD_F00D);
        chk("fl_no_valid", 32'(rdata_valid), 32'd0);
        chk("fl_bus_req_drop", 32'(bus_req), 32'd0);
        tick();

        // asynchronous reset during REQ
        issue(1'b0, 3'b010, 32'h0000_0104, 32'h0);
        tick();
        chk("rr_bus_req", 32'(bus_req), 32'd1);
        #2;
        rst = 1'b1; mreq = 1'b0;
        #1;
        chk("rr_bus_req_async", 32'(bus_req), 32'd0);
        chk("rr_stall_idle", 32'(stall), 32'd0);
        chk("rr_rdata_clr", rdata, 32'h0);
        chk("rr_bus_be_clr", 32'(bus_be), 32'h0);
        #1;
        rst = 1'b0;
        tick();
        chk("rr_idle_after", 32'(bus_req), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
